// File: rtl/mem_pkg.sv
// Shared types and constants for the multicycle memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } mem_op_t;

   localparam int MEM_LATENCY_DEF = 4;
   localparam int MEM_DEPTH_DEF   = 16384;
   localparam int MEM_IDX_W       = $clog2(MEM_DEPTH_DEF);
   localparam int MEM_CNT_W       = 4;

   // Byte address to word index, wrapping at the array depth.
   function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] depth);
      return (addr >> 2) % depth;
   endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter used to time the BUSY phase of the memory responder.
module mem_latency_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic [WIDTH-1:0] value,
   output logic             hit_one
);

   always_ff @(posedge clk) begin
      if (!reset)
         value <= '0;
      else if (load)
         value <= load_value;
      else if (dec)
         value <= value - 1'b1;
   end

   assign hit_one = (value == WIDTH'(1));

endmodule

// File: rtl/multicycle_mem_responder.sv
// Fixed-latency memory responder for the multicycle CPU's MemRead/MemWrite handshake.
// Optional byte-lane write strobes are enabled by defining MEM_BYTE_STROBE_EN.
module multicycle_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = MEM_DEPTH_DEF,
   parameter int LATENCY     = MEM_LATENCY_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [31:0]           addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  ready,
   output logic                  busy,
   output logic                  req_err
`ifdef MEM_BYTE_STROBE_EN
   ,
   input  logic [DATA_WIDTH/8-1:0] wstrb
`endif
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [MEM_CNT_W-1:0] LOAD_VAL = MEM_CNT_W'(LATENCY - 1);

   mem_state_t state, state_nxt;

   mem_op_t               op_q;
   logic [IDX_W-1:0]      idx_q;
   logic [DATA_WIDTH-1:0] data_q;
`ifdef MEM_BYTE_STROBE_EN
   logic [DATA_WIDTH/8-1:0] wstrb_q;
`endif

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   logic                 accept;
   logic                 conflict;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_hit_one;
   logic [MEM_CNT_W-1:0] cnt_value;

   mem_latency_counter #(
      .WIDTH(MEM_CNT_W)
   ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .load      (cnt_load),
      .load_value(LOAD_VAL),
      .dec       (cnt_dec),
      .value     (cnt_value),
      .hit_one   (cnt_hit_one)
   );

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      conflict  = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_read ^ mem_write) begin
               accept    = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = (LATENCY == 1) ? DONE : BUSY;
            end else if (mem_read && mem_write) begin
               conflict = 1'b1;
            end
         end
         BUSY: begin
            cnt_dec = (cnt_value != '0);
            if (cnt_hit_one)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control and registered outputs; DONE actions take effect on the edge leaving DONE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         ready   <= 1'b0;
         busy    <= 1'b0;
         req_err <= 1'b0;
         dout    <= '0;
      end else begin
         state   <= state_nxt;
         ready   <= (state == DONE);
         busy    <= accept || (state == BUSY);
         req_err <= conflict;
         if (state == DONE && op_q == OP_RD)
            dout <= mem[idx_q];
      end
   end

   // Request capture at accept; later input changes cannot disturb the access.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= mem_write ? OP_WR : OP_RD;
         idx_q  <= IDX_W'(word_index(addr, 32'(DEPTH_WORDS)));
         data_q <= din;
`ifdef MEM_BYTE_STROBE_EN
         wstrb_q <= wstrb;
`endif
      end
   end

   // Array commit is gated by reset so an abandoned write leaves memory intact.
   always_ff @(posedge clk) begin
      if (reset && state == DONE && op_q == OP_WR) begin
`ifdef MEM_BYTE_STROBE_EN
         for (int b = 0; b < DATA_WIDTH/8; b++)
            if (wstrb_q[b])
               mem[idx_q][b*8 +: 8] <= data_q[b*8 +: 8];
`else
         mem[idx_q] <= data_q;
`endif
      end
   end

endmodule

// File: doc/multicycle_mem_responder.md
# multicycle_mem_responder

Responder end of the multicycle CPU's memory control interface. It accepts MemRead/MemWrite requests issued by the multicycle control unit during its IF and MEM phases. It serves each request after a fixed, parameterised latency and signals completion with a one-cycle `ready` pulse. It replaces the combinational memory model, so the fetch and load/store states can be driven by a real handshake instead of a hard-coded cycle count.

## Interface
- `DATA_WIDTH`, 32, word width in bits; addresses are byte addresses.
- `DEPTH_WORDS`, 16384, number of words in the array.
- `LATENCY`, 4, cycles from request acceptance to `ready`; legal range 1–15.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-low. Asserted when 0 and sampled only on the rising edge of `clk`.
- `mem_read` input 1: read request, level.
- `mem_write` input 1: write request, level.
- `addr` input 32: byte address. `addr[1:0]` is ignored; word index = `(addr >> 2) mod DEPTH_WORDS`.
- `din` input DATA_WIDTH: write data.
- `dout` output DATA_WIDTH: read data, registered.
- `ready` output 1: one-cycle completion pulse, for both reads and writes.
- `busy` output 1: high while a request is in flight.
- `req_err` output 1: one-cycle pulse when `mem_read` and `mem_write` are both high in IDLE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If exactly one of `mem_read`/`mem_write` is high, latch the op, word index, and `din`.
  - Load the counter with `LATENCY-1`, set `busy`=1, and go to BUSY. If `LATENCY`==1, go straight to DONE.
  - If both are high: pulse `req_err`, accept nothing, stay in IDLE.
  - If neither is high: stay in IDLE.
- BUSY: decrement the counter each cycle. When it reaches 1, go to DONE. Inputs are ignored; the latched values are authoritative.
- DONE:
  - Write: commit the latched data to the array.
  - Read: load `dout` from the array at the latched index.
  - Either way: `ready`=1, `busy`=0, next state IDLE.
- After DONE, IDLE samples the request level again. The requester must drop the request in the cycle `ready` is high, or a second identical access is started.
- `dout` holds its value until the next read completes. Writes never change `dout`.
- Array contents are not reset. Contents are initialised only by the testbench.

## Timing
- A request is accepted at rising edge E0 (IDLE samples it). `ready` and `dout` are valid in the cycle following edge E0+LATENCY.
- Back-to-back requests: the next accept happens at the edge after `ready`. Throughput is one access per LATENCY+1 cycles.
- Write visibility: a read accepted after a write's `ready` returns the new data.
- Reset values: `dout`=0, `ready`=0, `busy`=0, `req_err`=0, state IDLE, counter 0.
- Reset while BUSY or DONE: the pending access is abandoned. A pending write does not modify the array, and no `ready` pulse is produced.
- Request changes during BUSY: ignored, with no effect on the in-flight access.
- Address wrap: index `DEPTH_WORDS` maps to index 0.

## Configuration
- `MEM_BYTE_STROBE_EN`:
  - Defined: adds input `wstrb` [DATA_WIDTH/8-1:0], latched at accept. In DONE, only byte lanes whose strobe bit is 1 are written; other bytes keep their old value. A write with `wstrb`=0 still produces `ready` but leaves the array unchanged.
  - Undefined: the port is absent and every write updates the full word.
- Read behaviour is identical in both builds.

## Structure
- Shared package `mem_pkg`:
  - State enum `mem_state_t` {IDLE, BUSY, DONE}.
  - Op enum `mem_op_t` {OP_RD, OP_WR}.
  - Default latency constant `MEM_LATENCY_DEF`=4.
  - Word-index helper width constant.
- One sub-module, `mem_latency_counter`: a loadable down-counter with a `load`, a `value`, and a `hit_one` flag. It is used by the FSM to time BUSY.
- The array is an inferred register/RAM in the top module.

## Test plan
- Read latency: preload word 0x10 = 0xDEADBEEF, hold `mem_read`=1 with `addr`=0x40. Expect `ready` exactly LATENCY=4 edges after accept, `dout`=0xDEADBEEF, and `busy` high for 4 cycles.
- Write then read: write 0x12345678 to `addr`=0x8, then read 0x8. Expect two `ready` pulses and `dout`=0x12345678; `dout` unchanged during the write.
- Conflict: `mem_read`=`mem_write`=1 in IDLE. Expect a one-cycle `req_err`, no `busy`, no `ready`, and the array unchanged.
- Reset mid-write: start a write of 0xAAAA5555 to 0x20, drive `reset`=0 on the second BUSY cycle. Expect all outputs 0, and a later read of 0x20 returns the old value.
- Input stability: change `addr`/`din` during BUSY. Expect the access to use the values latched at accept.
- With `MEM_BYTE_STROBE_EN`: word = 0x11223344, write 0xAABBCCDD with `wstrb`=4'b0101. Expect a read to return 0x11BB33DD.
